reg_file_sb: RTL

Parametrised successor to the processor's 8x16 register file. It provides two read ports and one write port, with configurable data width and depth. It adds three things the earlier block lacks: optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register scoreboard (reserve/release) for hazard detection by the decode stage. A sequential clear engine wipes the array on request without a reset.

---
 rtl/reg_file_sb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Parametrised two-read/one-write register file with optional write bypass,
// optional hardwired-zero register 0, per-register busy scoreboard and a clear sweep.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              regen,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0] data_result,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] data_A,
  output logic [DATA_W-1:0] data_B,
  output logic              busy_A,
  output logic              busy_B,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic              r_clr_done, w_clr_done_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy, w_busy_next;

  logic [DATA_W-1:0] r_data_a, r_data_b;
  logic              r_busy_a, r_busy_b;

  logic              w_op, w_wr, w_rsv, w_sweep;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;
  logic              w_bsy_a, w_bsy_b;

  assign w_sweep = (r_state == S_SWEEP);
  assign w_op    = en && (r_state == S_IDLE);
  assign w_wr    = w_op && regen  && !(ZR && (writereg == '0));
  assign w_rsv   = w_op && rsv_en && !(ZR && (rsv_addr == '0));

  // Reserve is applied after the write-clear so a same-cycle reserve wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr)    w_busy_next[writereg] = 1'b0;
    if (w_rsv)   w_busy_next[rsv_addr] = 1'b1;
    if (w_sweep) w_busy_next[r_cnt]    = 1'b0;
  end

  // Read ports see the post-edge busy state and, with bypass, the post-edge data.
  always_comb begin
    w_rd_a  = (BP && w_wr && (writereg == readreg1)) ? data_result : r_mem[readreg1];
    w_rd_b  = (BP && w_wr && (writereg == readreg2)) ? data_result : r_mem[readreg2];
    w_bsy_a = w_busy_next[readreg1];
    w_bsy_b = w_busy_next[readreg2];
    if (ZR && (readreg1 == '0)) begin
      w_rd_a  = '0;
      w_bsy_a = 1'b0;
    end
    if (ZR && (readreg2 == '0)) begin
      w_rd_b  = '0;
      w_bsy_b = 1'b0;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_clr_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_next = S_SWEEP;
          w_cnt_next   = '0;
        end
      end
      S_SWEEP: begin
        if (r_cnt == LAST_IDX) begin
          w_state_next    = S_IDLE;
          w_cnt_next      = '0;
          w_clr_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
      r_busy     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_clr_done <= w_clr_done_next;
      r_busy     <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_sweep) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[writereg] <= data_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_busy_a <= 1'b0;
      r_busy_b <= 1'b0;
    end else if (w_op) begin
      r_data_a <= w_rd_a;
      r_data_b <= w_rd_b;
      r_busy_a <= w_bsy_a;
      r_busy_b <= w_bsy_b;
    end
  end

  assign data_A   = r_data_a;
  assign data_B   = r_data_b;
  assign busy_A   = r_busy_a;
  assign busy_B   = r_busy_b;
  assign clr_busy = w_sweep;
  assign clr_done = r_clr_done;

endmodule
